// File: rtl/mul_tc_rr_arbiter.sv
// Round-robin arbiter sharing one signed 16x16 multiplier between NREQ requesters,
// with a two-stage (operand / result) pipeline and a tagged, backpressured response port.

module mul_tc_16_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] product
);
  logic signed [31:0] a_ext;
  logic signed [31:0] b_ext;

  assign a_ext   = {{16{a[15]}}, a};
  assign b_ext   = {{16{b[15]}}, b};
  assign product = a_ext * b_ext;
endmodule

module mul_tc_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*16-1:0]   req_a,
  input  logic [NREQ*16-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_product
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gidx;
  logic [PW-1:0]   idx;
  logic            found;
  logic [NREQ-1:0] grant;
  logic [15:0]     a_sel;
  logic [15:0]     b_sel;

  logic            s1_v;
  logic [IDW-1:0]  s1_id;
  logic [15:0]     s1_a;
  logic [15:0]     s1_b;
  logic [31:0]     product;

  logic            s2_adv;
  logic            s1_adv;

  assign s2_adv = !rsp_valid || rsp_ready;
  assign s1_adv = !s1_v || s2_adv;

  // Search starts just past the last accepted requester so priority rotates.
  always_comb begin
    grant = '0;
    gidx  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        gidx        = idx;
      end
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        a_sel = req_a[i*16 +: 16];
        b_sel = req_b[i*16 +: 16];
      end
    end
  end

  assign req_ready = (rst || !s1_adv) ? '0 : grant;

  mul_tc_16_16 u_mul (
    .a       (s1_a),
    .b       (s1_b),
    .product (product)
  );

  // Both stages shift together when the consumer drains S2, giving one accept per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= PW'(NREQ - 1);
      s1_v        <= 1'b0;
      s1_id       <= '0;
      s1_a        <= '0;
      s1_b        <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
    end else begin
      if (s1_adv) begin
        s1_v <= found;
        if (found) begin
          s1_id <= IDW'(gidx);
          s1_a  <= a_sel;
          s1_b  <= b_sel;
          ptr   <= gidx;
        end
      end
      if (s2_adv) begin
        rsp_valid   <= s1_v;
        rsp_id      <= s1_id;
        rsp_product <= product;
      end
    end
  end
endmodule

// File: tb/tb_mul_tc_rr_arbiter.sv
// Directed self-checking bench for mul_tc_rr_arbiter (NREQ=4): reset, single request,
// corner operands, fairness, backpressure, sparse requesters and reset mid-flight.

module tb_mul_tc_rr_arbiter;
  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_product;

  int checks = 0;
  int errors = 0;

  mul_tc_rr_arbiter #(.NREQ(4), .IDW(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Drive handshake inputs, then let combinational req_ready settle.
  task automatic applyStimulus(input logic [3:0] valid, input logic rready);
    req_valid = valid;
    rsp_ready = rready;
    #1;
  endtask

  task automatic setOp(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
  endtask

  // One-cycle synchronous reset, inputs idle; returns at the negedge after it.
  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(4'b0000, 1'b1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Requester i presents a=1000*(i+1), b=-3*(i+2).
  int fair_prod [4] = '{-6000, -18000, -36000, -60000};

  task automatic loadFairOps();
    for (int i = 0; i < 4; i++)
      setOp(i, 16'(1000 * (i + 1)), 16'(-3 * (i + 2)));
  endtask

  logic [15:0] ca [4] = '{16'h8000, 16'h8000, 16'h7FFF, 16'h0000};
  logic [15:0] cb [4] = '{16'h8000, 16'h7FFF, 16'h7FFF, 16'hFFFF};
  logic [31:0] cp [4] = '{32'h40000000, 32'hC0008000, 32'h3FFF0001, 32'h00000000};

  logic [3:0] bp_rr [12] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                             4'b0000, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
  logic       bp_v  [12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                             1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  int         bp_id [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 0};

  initial begin
    rst       = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;

    // Reset state, with req_ready held low during reset even though requests are valid
    @(negedge clk);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("reset_rsp_product", rsp_product, 32'd0);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);

    // Single request: -5 * 7 = -35
    rst = 1'b0;
    setOp(0, 16'hFFFB, 16'd7);
    applyStimulus(4'b0001, 1'b1);
    checkOutput("single_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("single_lat1_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    checkOutput("single_valid", 32'(rsp_valid), 32'd1);
    checkOutput("single_id", 32'(rsp_id), 32'd0);
    checkOutput("single_product", rsp_product, 32'hFFFFFFDD);
    @(negedge clk);
    checkOutput("single_once", 32'(rsp_valid), 32'd0);

    // Corner operands, back to back on requester 0
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (t < 4) begin
        setOp(0, ca[t], cb[t]);
        applyStimulus(4'b0001, 1'b1);
        checkOutput("corner_ready", 32'(req_ready), 32'h1);
      end else begin
        applyStimulus(4'b0000, 1'b1);
      end
      if (t >= 2) begin
        checkOutput("corner_valid", 32'(rsp_valid), 32'd1);
        checkOutput("corner_product", rsp_product, cp[t-2]);
      end
    end

    // Fairness: all four valid for 12 cycles
    applyReset();
    loadFairOps();
    for (int t = 0; t < 14; t++) begin
      @(negedge clk);
      applyStimulus((t < 12) ? 4'b1111 : 4'b0000, 1'b1);
      checkOutput("fair_ready", 32'(req_ready), (t < 12) ? (32'h1 << (t % 4)) : 32'h0);
      if (t >= 2) begin
        checkOutput("fair_valid", 32'(rsp_valid), 32'd1);
        checkOutput("fair_id", 32'(rsp_id), 32'((t - 2) % 4));
        checkOutput("fair_product", rsp_product, 32'(fair_prod[(t-2)%4]));
      end else begin
        checkOutput("fair_fill_valid", 32'(rsp_valid), 32'd0);
      end
    end

    // Backpressure: rsp_ready low for cycles 0..6, released at 7
    applyReset();
    loadFairOps();
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      applyStimulus((t < 9) ? 4'b1111 : 4'b0000, (t >= 7));
      checkOutput("bp_ready", 32'(req_ready), 32'(bp_rr[t]));
      checkOutput("bp_valid", 32'(rsp_valid), 32'(bp_v[t]));
      if (bp_v[t]) begin
        checkOutput("bp_id", 32'(rsp_id), 32'(bp_id[t]));
        checkOutput("bp_product", rsp_product, 32'(fair_prod[bp_id[t]]));
      end
    end

    // Sparse: move ptr to 1, then only requesters 1 and 3 valid
    applyReset();
    @(negedge clk);
    applyStimulus(4'b0010, 1'b1);
    checkOutput("sparse_setup", 32'(req_ready), 32'h2);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      applyStimulus(4'b1010, 1'b1);
      checkOutput("sparse_ready", 32'(req_ready), (t % 2 == 0) ? 32'h8 : 32'h2);
    end
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      applyStimulus(4'b0000, 1'b1);
    end

    // Reset mid-flight: fill S1 and S2 under backpressure, then reset
    @(negedge clk);
    setOp(0, 16'hFFF9, 16'd9);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("rmf_fill1", 32'(req_ready), 32'h1);
    @(negedge clk);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("rmf_fill2", 32'(req_ready), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(4'b0001, 1'b0);
    checkOutput("rmf_full_valid", 32'(rsp_valid), 32'd1);
    checkOutput("rmf_reset_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    setOp(0, 16'd3, 16'd4);
    setOp(2, 16'd5, 16'd5);
    applyStimulus(4'b0101, 1'b1);
    checkOutput("rmf_after_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rmf_after_grant", 32'(req_ready), 32'h1);
    @(negedge clk);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("rmf_no_stale", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    checkOutput("rmf_new_valid", 32'(rsp_valid), 32'd1);
    checkOutput("rmf_new_id", 32'(rsp_id), 32'd0);
    checkOutput("rmf_new_product", rsp_product, 32'd12);
    @(negedge clk);
    checkOutput("rmf_drained", 32'(rsp_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
